sccb_rd: RTL and testbench

//  SCCB read master for the OV5640 configuration bus, the read-direction counterpart to the SCCB write master.

---
 rtl/sccb_rd_if.sv | 22 ++
 rtl/sccb_rd.sv | 192 +++++++++++++++++++
 tb/tb_sccb_rd.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_rd_if.sv
// Request/response interface of the SCCB read master.
// The requester uses the master modport and sccb_rd uses the slave modport.
interface sccb_rd_if;
    logic        sccb_exec;
    logic        bit_ctrl;
    logic [15:0] sccb_addr;
    logic [6:0]  SLAVE_ADDR;
    logic        sccb_busy;
    logic        sccb_done;
    logic [7:0]  sccb_data_rd;
    logic        sccb_ack_err;

    modport master (
        output sccb_exec, bit_ctrl, sccb_addr, SLAVE_ADDR,
        input  sccb_busy, sccb_done, sccb_data_rd, sccb_ack_err
    );

    modport slave (
        input  sccb_exec, bit_ctrl, sccb_addr, SLAVE_ADDR,
        output sccb_busy, sccb_done, sccb_data_rd, sccb_ack_err
    );
endinterface

// File: rtl/sccb_rd.sv
// SCCB read master for OV5640.
// Writes the register pointer, leaves a bus-free gap, then reads one byte back.
// Each protocol slot is four quarter-bit periods. sio_c and sio_d are decoded
// directly from the slot state so that a reset releases the bus immediately.
module sccb_rd #(
    parameter logic [25:0] CLK_FREQ  = 26'd50_000_000,
    parameter logic [17:0] SCCB_FREQ = 18'd250_000
) (
    input  logic     clk,
    input  logic     rst_n,
    sccb_rd_if.slave bus,
    output logic     sio_c,
    inout  wire      sio_d
);
    // Widen before multiplying: SCCB_FREQ*4 does not fit in 18 bits.
    localparam int unsigned TICK_DIV = 32'(CLK_FREQ) / (32'(SCCB_FREQ) * 32'd4);
    localparam int unsigned DIV_W    = $clog2(TICK_DIV);

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StStartW = 4'd1;
    localparam logic [3:0] StIdW    = 4'd2;
    localparam logic [3:0] StAddrH  = 4'd3;
    localparam logic [3:0] StAddrL  = 4'd4;
    localparam logic [3:0] StStopW  = 4'd5;
    localparam logic [3:0] StGap    = 4'd6;
    localparam logic [3:0] StStartR = 4'd7;
    localparam logic [3:0] StIdR    = 4'd8;
    localparam logic [3:0] StRd     = 4'd9;
    localparam logic [3:0] StNa     = 4'd10;
    localparam logic [3:0] StStopR  = 4'd11;
    localparam logic [3:0] StDone   = 4'd12;

    logic [3:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       qtr_q;
    logic [3:0]       bit_q, bit_d;
    logic             bc_q;
    logic [15:0]      addr_q;
    logic [6:0]       id_q;
    logic [7:0]       rx_q;
    logic             err_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       data_q;

    logic             active;
    logic             tick;
    logic             is_byte;
    logic [7:0]       tx_byte;
    logic             sd_oe;
    logic             sd_out;

    assign active  = (state_q != StIdle) && (state_q != StDone);
    assign tick    = active && (div_q == DIV_W'(TICK_DIV - 1));
    assign is_byte = (state_q == StIdW) || (state_q == StAddrH) ||
                     (state_q == StAddrL) || (state_q == StIdR);

    assign bus.sccb_busy    = busy_q;
    assign bus.sccb_done    = done_q;
    assign bus.sccb_data_rd = data_q;
    assign bus.sccb_ack_err = err_q;

    assign sio_d = sd_oe ? sd_out : 1'bz;

    // Byte being shifted out in the current byte slot.
    always_comb begin
        case (state_q)
            StIdW:   tx_byte = {id_q, 1'b0};
            StAddrH: tx_byte = addr_q[15:8];
            StAddrL: tx_byte = addr_q[7:0];
            StIdR:   tx_byte = {id_q, 1'b1};
            default: tx_byte = 8'hFF;
        endcase
    end

    // Slot sequencing applied at the end of each slot.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q + 4'd1;
        case (state_q)
            StStartW: begin state_d = StIdW; bit_d = '0; end
            StIdW:    if (bit_q == 4'd8) begin state_d = bc_q ? StAddrH : StAddrL; bit_d = '0; end
            StAddrH:  if (bit_q == 4'd8) begin state_d = StAddrL; bit_d = '0; end
            StAddrL:  if (bit_q == 4'd8) begin state_d = StStopW; bit_d = '0; end
            StStopW:  state_d = StGap;
            StGap:    state_d = StStartR;
            StStartR: begin state_d = StIdR; bit_d = '0; end
            StIdR:    if (bit_q == 4'd8) begin state_d = StRd; bit_d = '0; end
            StRd:     if (bit_q == 4'd7) begin state_d = StNa; bit_d = '0; end
            StNa:     state_d = StStopR;
            StStopR:  state_d = StDone;
            default:  state_d = StIdle;
        endcase
    end

    // Bus line decode per slot type and quarter.
    always_comb begin
        sio_c  = 1'b1;
        sd_oe  = 1'b0;
        sd_out = 1'b1;
        case (state_q)
            StStartW, StStartR: begin
                sio_c  = (qtr_q != 2'd3);
                sd_oe  = 1'b1;
                sd_out = ~qtr_q[1];
            end
            StIdW, StAddrH, StAddrL, StIdR: begin
                sio_c  = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                // Ninth bit is the slave's X bit: release.
                sd_oe  = (bit_q != 4'd8);
                sd_out = tx_byte[3'd7 - bit_q[2:0]];
            end
            StRd: begin
                sio_c = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            end
            StNa: begin
                sio_c  = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sd_oe  = 1'b1;
                sd_out = 1'b1;
            end
            StStopW, StStopR: begin
                sio_c  = (qtr_q != 2'd0);
                sd_oe  = 1'b1;
                sd_out = qtr_q[1];
            end
            StGap: begin
                sd_oe  = 1'b1;
                sd_out = 1'b1;
            end
            default: begin
                sio_c = 1'b1;
            end
        endcase
    end

    // Transaction state, quarter-tick prescaler, sampling and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            bc_q    <= 1'b0;
            addr_q  <= '0;
            id_q    <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == StIdle) begin
                div_q <= '0;
                qtr_q <= '0;
                bit_q <= '0;
                if (bus.sccb_exec) begin
                    state_q <= StStartW;
                    bc_q    <= bus.bit_ctrl;
                    addr_q  <= bus.sccb_addr;
                    id_q    <= bus.SLAVE_ADDR;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b1;
                end
            end else if (state_q == StDone) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                div_q <= tick ? '0 : div_q + DIV_W'(1);
                if (tick) begin
                    qtr_q <= qtr_q + 2'd1;
                    if (qtr_q == 2'd2) begin
                        if (is_byte && bit_q == 4'd8) begin
                            err_q <= err_q | sio_d;
                        end
                        if (state_q == StRd) begin
                            rx_q <= {rx_q[6:0], sio_d};
                        end
                    end
                    if (qtr_q == 2'd3) begin
                        state_q <= state_d;
                        bit_q   <= bit_d;
                        if (state_q == StStopR) begin
                            done_q <= 1'b1;
                            data_q <= rx_q;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sccb_rd.sv
// Randomised scoreboard bench for sccb_rd with a behavioural SCCB slave.
`timescale 1ns/1ps
module tb_sccb_rd;
    localparam logic [9:0] TOK_S = 10'h200;
    localparam logic [9:0] TOK_P = 10'h300;

    typedef struct packed {
        logic [7:0]       data;
        logic             err;
        logic [15:0]      lat;
        logic [3:0]       ntok;
        logic [8:0][9:0]  tok;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire  sio_c;
    wire  sio_d;
    logic slave_drv = 1'b0;
    logic rd_mode = 1'b0;

    int nvec = 0;
    int nfail = 0;
    int done_cnt = 0;
    int cyc = 0;

    exp_t       exp_q[$];
    logic [9:0] bus_log[$];

    pullup (sio_d);
    assign sio_d = slave_drv ? 1'b0 : 1'bz;

    sccb_rd_if bus();

    sccb_rd #(
        .CLK_FREQ (26'd4_000_000),
        .SCCB_FREQ(18'd250_000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .sio_c(sio_c),
        .sio_d(sio_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected bus transcript and result built straight from the protocol rules.
    function automatic exp_t make_exp(input logic bc, input logic [15:0] addr,
                                      input logic [6:0] id, input logic [7:0] data,
                                      input logic ack);
        exp_t e;
        int   n;
        logic x;
        x = ~ack;
        e = '0;
        n = 0;
        e.tok[n] = TOK_S;                   n++;
        e.tok[n] = {1'b0, id, 1'b0, x};     n++;
        if (bc) begin
            e.tok[n] = {1'b0, addr[15:8], x}; n++;
        end
        e.tok[n] = {1'b0, addr[7:0], x};    n++;
        e.tok[n] = TOK_P;                   n++;
        e.tok[n] = TOK_S;                   n++;
        e.tok[n] = {1'b0, id, 1'b1, x};     n++;
        e.tok[n] = {1'b0, data, 1'b1};      n++;
        e.tok[n] = TOK_P;                   n++;
        e.ntok = 4'(n);
        e.data = data;
        e.err  = x;
        e.lat  = bc ? 16'd800 : 16'd656;
        return e;
    endfunction

    // Slave response for bit number n (0-based) of the current cycle.
    function automatic logic slave_want(input int n);
        logic [7:0] d;
        logic       a;
        d = 8'hFF;
        a = 1'b1;
        if (exp_q.size() > 0) begin
            d = exp_q[0].data;
            a = ~exp_q[0].err;
        end
        if (rd_mode && n >= 9) return (n <= 16) ? ~d[16 - n] : 1'b0;
        if (n % 9 == 8) return a;
        return 1'b0;
    endfunction

    // Slave and bus decoder: logs S/P/bytes, changes sio_d mid low phase of sio_c.
    initial begin : slave_proc
        logic pc, pd, c, d;
        int nb, cnt;
        logic [8:0] sh;
        pc = 1'b1; pd = 1'b1; nb = 0; cnt = 0; sh = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pc = 1'b1; pd = 1'b1; nb = 0; cnt = 0;
                slave_drv = 1'b0;
                rd_mode = 1'b0;
            end else begin
                c = sio_c;
                d = sio_d;
                if (pc && c && pd && !d) begin
                    nb = 0;
                    rd_mode = 1'b0;
                    bus_log.push_back(TOK_S);
                end else if (pc && c && !pd && d) begin
                    bus_log.push_back(TOK_P);
                end
                if (c && !pc) begin
                    sh = {sh[7:0], d};
                    nb++;
                    if (nb == 8) rd_mode = sh[0];
                    if (nb % 9 == 0) bus_log.push_back({1'b0, sh});
                end
                if (!c && pc) begin
                    slave_drv = 1'b0;
                    cnt = 6;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) slave_drv = slave_want(nb);
                end
                pc = c;
                pd = d;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reports completion.
    initial begin : mon_proc
        logic pb, pdn;
        logic [7:0] held;
        int acc, m;
        exp_t e;
        pb = 1'b0; pdn = 1'b0; acc = 0; held = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb = 1'b0; pdn = 1'b0; held = 8'h00;
            end else begin
                if (bus.sccb_busy && !pb) begin
                    acc = cyc;
                    chk("data_rd_hold", bus.sccb_data_rd, held);
                end
                if (pdn && !bus.sccb_done) begin
                    chk("idle_sio_c", sio_c, 1);
                    chk("idle_sio_d", sio_d, 1);
                    chk("busy_after_done", bus.sccb_busy, 0);
                end
                if (bus.sccb_done) begin
                    done_cnt++;
                    chk("done_width", pdn, 0);
                    chk("busy_with_done", bus.sccb_busy, 1);
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL unexpected_done: got a done pulse, required none (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_rd", bus.sccb_data_rd, e.data);
                        chk("ack_err", bus.sccb_ack_err, e.err);
                        chk("latency", cyc - acc, e.lat);
                        chk("bus_len", bus_log.size(), e.ntok);
                        m = (bus_log.size() < int'(e.ntok)) ? bus_log.size() : int'(e.ntok);
                        for (int i = 0; i < m; i++) chk("bus_tok", bus_log[i], e.tok[i]);
                    end
                    bus_log.delete();
                    held = bus.sccb_data_rd;
                end
                pb = bus.sccb_busy;
                pdn = bus.sccb_done;
            end
        end
    end

    task automatic wait_done(input int n);
        int target;
        int i;
        target = done_cnt + n;
        i = 0;
        while (done_cnt < target && i < 2000 * n) begin
            @(negedge clk);
            i++;
        end
        chk("done_timeout", done_cnt >= target, 1);
    endtask

    // Launch one read; inputs are scrambled after accept to prove they are latched.
    task automatic issue(input logic bc, input logic [15:0] addr, input logic [6:0] id,
                         input logic [7:0] data, input logic ack);
        exp_q.push_back(make_exp(bc, addr, id, data, ack));
        bus.bit_ctrl   = bc;
        bus.sccb_addr  = addr;
        bus.SLAVE_ADDR = id;
        bus.sccb_exec  = 1'b1;
        @(negedge clk);
        bus.sccb_exec  = 1'b0;
        bus.bit_ctrl   = 1'($urandom);
        bus.sccb_addr  = 16'($urandom);
        bus.SLAVE_ADDR = 7'($urandom);
    endtask

    task automatic run_one(input logic bc, input logic [15:0] addr, input logic [6:0] id,
                           input logic [7:0] data, input logic ack);
        issue(bc, addr, id, data, ack);
        wait_done(1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        logic [15:0] a;
        bus.sccb_exec  = 1'b0;
        bus.bit_ctrl   = 1'b0;
        bus.sccb_addr  = '0;
        bus.SLAVE_ADDR = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.sccb_busy, 0);
        chk("rst_done", bus.sccb_done, 0);
        chk("rst_data", bus.sccb_data_rd, 8'h00);
        chk("rst_err", bus.sccb_ack_err, 0);
        chk("rst_sio_c", sio_c, 1);
        chk("rst_sio_d", sio_d, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_one(1'b1, 16'h300A, 7'h3C, 8'h56, 1'b1);
        run_one(1'b0, 16'hFF42, 7'h3C, 8'hA5, 1'b1);
        run_one(1'b1, 16'($urandom), 7'h3C, 8'hFF, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_one(1'($urandom), 16'($urandom), 7'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0));
        end

        // Address change and exec re-pulse while busy are ignored.
        a = 16'($urandom);
        issue(1'b1, a, 7'h3C, 8'hC3, 1'b1);
        repeat (300) @(negedge clk);
        bus.sccb_addr = ~a;
        bus.sccb_exec = 1'b1;
        @(negedge clk);
        bus.sccb_exec = 1'b0;
        wait_done(1);
        repeat (40) @(negedge clk);
        chk("no_restart_busy", bus.sccb_busy, 0);

        // Reset during the q3 quarter of read bit 3.
        issue(1'b1, 16'h1234, 7'h3C, 8'h00, 1'b1);
        repeat (700) @(posedge clk);
        #1;
        chk("pre_rst_sio_c", sio_c, 0);
        chk("pre_rst_busy", bus.sccb_busy, 1);
        #1;
        rst_n = 1'b0;
        slave_drv = 1'b0;
        #1;
        chk("mid_rst_sio_c", sio_c, 1);
        chk("mid_rst_sio_d", sio_d, 1);
        chk("mid_rst_busy", bus.sccb_busy, 0);
        chk("mid_rst_data", bus.sccb_data_rd, 8'h00);
        exp_q.delete();
        bus_log.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_one(1'b1, 16'h300A, 7'h3C, 8'h9E, 1'b1);

        // Back-to-back reads with sccb_exec held high.
        exp_q.push_back(make_exp(1'b1, 16'h3100, 7'h3C, 8'h12, 1'b1));
        exp_q.push_back(make_exp(1'b1, 16'h3100, 7'h3C, 8'h34, 1'b1));
        bus.bit_ctrl   = 1'b1;
        bus.sccb_addr  = 16'h3100;
        bus.SLAVE_ADDR = 7'h3C;
        bus.sccb_exec  = 1'b1;
        wait_done(1);
        repeat (3) @(negedge clk);
        bus.sccb_exec = 1'b0;
        wait_done(1);
        repeat (20) @(negedge clk);
        chk("pending_exp", exp_q.size(), 0);
        chk("final_busy", bus.sccb_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
